subword_mem_ctrl: RTL
=====================

Name: subword_mem_ctrl

Overview:
- Multi-cycle sequencer between the CPU memory stage and a word-wide, handshaked data memory.
- Executes LW/LH/LHU/LB/LBU/SW/SH/SB using the Mode encoding from the control decoder: 00 byte, 01 half, 10 word.
- Sub-word stores use read-modify-write. Misaligned accesses are rejected, and a watchdog aborts a memory access that is never acknowledged.
- Stalls the pipeline while an access is in flight.

Parameters:
- TIMEOUT, 255, maximum cycles to wait for mem_ack in one memory transaction before aborting (must be ≥ 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  memory-stage instruction is a load or store (Memtoreg|Memwrite)
- req_write  in  1  1 = store, 0 = load
- req_mode  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_signed  in  1  sign-extend a load result (LB/LH); 0 = zero-extend (LBU/LHU); ignored for word and for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  high only in IDLE
- stall  out  1  freeze the pipeline
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; valid with rsp_valid
- misaligned  out  1  pulses with rsp_valid on an alignment fault
- bus_err  out  1  pulses with rsp_valid on a watchdog timeout
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address; {req_addr[31:2], 2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  read data; valid with mem_ack
- mem_ack  in  1  transaction complete; sampled on the rising edge while mem_req = 1

Behaviour:
- States: IDLE, READ, WRITE, DONE.
  - mem_req = (state == READ or state == WRITE).
  - mem_we = (state == WRITE).
- Request capture:
  - A request is accepted when req_valid && req_ready.
  - On acceptance, req_write, req_mode, req_signed, address and wdata are registered.
  - The request inputs are ignored outside IDLE.
- stall = (IDLE && req_valid) || READ || WRITE.
  - stall is low in DONE, so the pipeline advances on the edge that ends DONE.
- IDLE transitions on acceptance:
  - Misaligned access → DONE with misaligned = 1. Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0. No memory transaction is issued.
  - Load, or sub-word store → READ.
  - Word store → WRITE, with mem_wdata = wdata.
- READ, on mem_ack:
  - Capture mem_rdata.
  - Load → DONE, with rsp_rdata = extracted value.
  - Sub-word store → WRITE, with mem_wdata = captured word with the addressed lane replaced.
- WRITE, on mem_ack → DONE, with rsp_rdata = 0.
- DONE: rsp_valid = 1 for exactly one cycle, then → IDLE. Every accepted request produces exactly one rsp_valid.
- Lanes are little-endian:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1], occupying bits [16·addr[1]+15 : 16·addr[1]].
  - Byte store replaces that byte lane with wdata[7:0]; half store replaces that half lane with wdata[15:0].
- Load extension:
  - Byte/half results are sign- or zero-extended per req_signed.
  - Word loads are passed through unchanged.
- Watchdog:
  - The counter clears on every entry to READ or WRITE, including the READ→WRITE transition.
  - It increments each cycle without mem_ack.
  - If the counter reaches TIMEOUT−1 with no ack in that cycle → DONE with bus_err = 1, rsp_rdata = 0. For a sub-word store that times out in READ, the write is abandoned.
  - An ack in the same cycle as the timeout wins.
- Latency:
  - Word load with an immediate ack: accept at edge T, READ during T..T+1, DONE after edge T+1, rsp_valid in cycle T+1 to T+2. That is 2 cycles of stall plus the DONE cycle.
  - Sub-word store adds one WRITE transaction.
- Reset values, asserted asynchronously: state = IDLE, and all outputs 0 (stall, rsp_valid, rsp_rdata, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_wdata); watchdog counter = 0.
- Reset mid-transaction: mem_req drops immediately and the in-flight operation is discarded. No rsp_valid is produced for it.
- misaligned and bus_err are never both 1.

Test Plan:
- LB signed: addr 0x0000_0103, memory word 0x80FF_1234, ack after 1 cycle → one READ, rsp_rdata = 0xFFFF_FF80, rsp_valid for one cycle. LBU at the same address → 0x0000_0080.
- SH: addr 0x0000_0102, wdata 0x0000_ABCD, old word 0x1122_3344 → READ then WRITE on mem_addr 0x0000_0100 with mem_wdata = 0xABCD_3344; stall high until DONE.
- LW misaligned: addr 0x0000_0101 → mem_req never asserts; misaligned = 1 and rsp_valid = 1 in the same single cycle.
- Timeout: TIMEOUT = 4, word load, mem_ack held low → bus_err and rsp_valid pulse after 4 READ cycles, rsp_rdata = 0. Repeat with the ack arriving in cycle 4 → normal load, no bus_err.
- Reset mid-WRITE of an SB → mem_req and stall drop asynchronously; after release, req_ready = 1 and no rsp_valid appears.
- Back-to-back: SW 0x0000_0200 followed immediately by LHU 0x0000_0202 → two independent completions; the LHU returns the upper half of the stored word, zero-extended.

Source files
------------

// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: multi-cycle load/store sequencer with sub-word read-modify-write, alignment check and ack watchdog
module subword_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          op_write, op_signed;
    logic [1:0]    op_mode;
    logic [31:0]   op_addr;
    logic [15:0]   op_wdata;
    logic [31:0]   wdata_q, wdata_nxt, rdata_q, rdata_nxt;
    logic          mis_q, mis_nxt, berr_q, berr_nxt;
    logic          req_mis, take, expired;
    logic [4:0]    bsh;
    logic [15:0]   lane;
    logic [31:0]   bmask, ext, merged;

    // half needs addr[0]=0, word (mode 1x) needs addr[1:0]=0
    assign req_mis = req_mode == 2'b01 ? req_addr[0] : req_mode[1] && req_addr[1:0] != 2'b00;
    // aligned halves have addr[0]=0, so one shift amount serves both byte and half lanes
    assign bsh     = {op_addr[1:0], 3'b000};
    assign lane    = 16'(mem_rdata >> bsh);
    assign ext     = op_mode[1] ? mem_rdata :
                     op_mode[0] ? {{16{op_signed & lane[15]}}, lane} :
                                  {{24{op_signed & lane[7]}}, lane[7:0]};
    assign bmask   = (op_mode[0] ? 32'h0000_ffff : 32'h0000_00ff) << bsh;
    assign merged  = (mem_rdata & ~bmask) | (({16'h0, op_wdata} << bsh) & bmask);
    assign expired = cnt == CW'(TIMEOUT - 1);
    assign mem_addr   = {op_addr[31:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign rsp_rdata  = rdata_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next state, handshake outputs and next datapath values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        mis_nxt   = 1'b0;
        berr_nxt  = 1'b0;
        take      = 1'b0;
        req_ready = state == IDLE;
        mem_req   = state == READ || state == WRITE;
        mem_we    = state == WRITE;
        rsp_valid = state == DONE;
        stall     = (state == IDLE && req_valid && rst_n) || mem_req;
        case (state)
            IDLE: if (req_valid) begin
                take      = 1'b1;
                cnt_nxt   = '0;
                rdata_nxt = '0;
                if (req_mis) begin
                    state_nxt = DONE;
                    mis_nxt   = 1'b1;
                end else if (req_write && req_mode[1]) begin
                    state_nxt = WRITE;
                    wdata_nxt = req_wdata;
                end else state_nxt = READ;
            end
            READ: if (mem_ack) begin
                cnt_nxt = '0;
                if (op_write) begin
                    state_nxt = WRITE;
                    wdata_nxt = merged;
                end else begin
                    state_nxt = DONE;
                    rdata_nxt = ext;
                end
            end else if (expired) begin
                state_nxt = DONE;
                berr_nxt  = 1'b1;
            end else cnt_nxt = cnt + 1'b1;
            WRITE: if (mem_ack) state_nxt = DONE;
            else if (expired) begin
                state_nxt = DONE;
                berr_nxt  = 1'b1;
            end else cnt_nxt = cnt + 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // request capture and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write  <= 1'b0;
            op_signed <= 1'b0;
            op_mode   <= 2'b00;
            op_addr   <= '0;
            op_wdata  <= '0;
            cnt       <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            if (take) begin
                op_write  <= req_write;
                op_signed <= req_signed;
                op_mode   <= req_mode;
                op_addr   <= req_addr;
                op_wdata  <= req_wdata[15:0];
            end
            cnt     <= cnt_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
            mis_q   <= mis_nxt;
            berr_q  <= berr_nxt;
        end
    end
endmodule
